mem_bus_bridge: RTL and testbench

Multi-cycle data-memory/IO bridge between the pipelined CPU's MEM-stage port and the shared memory/peripheral bus. It registers each CPU load/store and drives one bus transaction with region select, honouring the bus ready handshake. It stalls the whole pipeline through `cpu_en` until the transaction completes. It also returns read data and records bus timeouts.

---
 rtl/mem_bus_bridge.sv | 123 ++++++++++++
 tb/tb_mem_bus_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// MEM-stage to memory/IO bus bridge: registers one CPU load/store, runs a single
// bus transaction with region select and ready handshake, stalls the pipeline meanwhile.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_en,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_ram_sel,
  output logic        bus_io_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic        w_capture;
  logic        w_ready;
  logic        w_timeout;
  logic        w_io;
  logic        w_unused_addr_lsb;

  assign w_capture         = (r_state == S_IDLE) && cpu_req;
  assign w_ready           = (r_state == S_ACCESS) && bus_ready;
  // Ready on the final counted cycle takes precedence over the timeout.
  assign w_timeout         = (r_state == S_ACCESS) && !bus_ready && (r_cnt == TO_LAST);
  assign w_io              = (r_addr[31:28] >= 4'hE);
  assign w_unused_addr_lsb = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req) w_next = S_ACCESS;
      S_ACCESS: if (w_ready || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_en      = 1'b1;
    bus_we      = 1'b0;
    bus_ram_sel = 1'b0;
    bus_io_sel  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:   cpu_en = ~cpu_req;
        S_ACCESS: begin
          cpu_en      = 1'b0;
          bus_we      = r_we;
          bus_ram_sel = ~w_io;
          bus_io_sel  = w_io;
        end
        S_DONE:   cpu_en = 1'b1;
        default:  cpu_en = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      if (w_capture) begin
        r_addr  <= {cpu_addr[31:2], 2'b00};
        r_wdata <= cpu_wdata;
        r_we    <= cpu_we;
        r_cnt   <= 8'd0;
      end
      if (r_state == S_ACCESS) r_cnt <= r_cnt + 8'd1;
      if (w_ready && !r_we) r_rdata <= bus_rdata;
      if (w_timeout) begin
        if (!r_we) r_rdata <= ERR_DATA;
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= r_addr;
      end
    end
  end

  assign cpu_rdata = r_rdata;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_err   = r_err;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: directed and random transactions checked against a
// transaction-level model of stall length, bus strobes, read data and error capture.
module tb_mem_bus_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_ram_sel;
  logic        bus_io_sel;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;
  logic [31:0] err_addr;

  mem_bus_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_en      (cpu_en),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_ram_sel (bus_ram_sel),
    .bus_io_sel  (bus_io_sel),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .bus_err     (bus_err),
    .err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_err_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"},  {31'd0, bus_we},      32'd0);
    chk({tag, "_ram"}, {31'd0, bus_ram_sel}, 32'd0);
    chk({tag, "_io"},  {31'd0, bus_io_sel},  32'd0);
  endtask

  // rdy_k: ACCESS cycle (1-based) on which the bus answers; 0 or > T means never.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_k, input logic [31:0] rdata, input bit hold);
    logic [31:0] a_al;
    logic        io;
    bit          finished;
    int          j;
    a_al     = {addr[31:2], 2'b00};
    io       = (addr[31:28] >= 4'hE);
    finished = 0;
    j        = 0;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    chk("idle_en", {31'd0, cpu_en}, 32'd0);
    chk_quiet("idle");
    while (!finished) begin
      j++;
      @(negedge clk);
      bus_ready = (j == rdy_k);
      bus_rdata = (j == rdy_k) ? rdata : $urandom;
      #1;
      chk("acc_en",    {31'd0, cpu_en},      32'd0);
      chk("acc_addr",  bus_addr,             a_al);
      chk("acc_wdata", bus_wdata,            wdata);
      chk("acc_we",    {31'd0, bus_we},      {31'd0, we});
      chk("acc_ram",   {31'd0, bus_ram_sel}, {31'd0, ~io});
      chk("acc_io",    {31'd0, bus_io_sel},  {31'd0, io});
      if (j == rdy_k || j == T) finished = 1;
    end
    if (!we) m_rdata = (j == rdy_k) ? rdata : ERR;
    if (j != rdy_k) begin
      if (!m_err) m_err_addr = a_al;
      m_err = 1'b1;
    end
    @(negedge clk);
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    chk("done_en",    {31'd0, cpu_en},  32'd1);
    chk_quiet("done");
    chk("done_rdata", cpu_rdata,        m_rdata);
    chk("done_err",   {31'd0, bus_err}, {31'd0, m_err});
    chk("done_eaddr", err_addr,         m_err_addr);
    if (!hold) begin
      @(negedge clk);
      cpu_req   = 1'b0;
      bus_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rest_en",    {31'd0, cpu_en}, 32'd1);
      chk_quiet("rest");
      chk("rest_rdata", cpu_rdata,       m_rdata);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_rdata    = 32'd0;
    m_err      = 1'b0;
    m_err_addr = 32'd0;
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 32'd0;
    cpu_wdata  = 32'd0;
    bus_rdata  = 32'd0;
    bus_ready  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_en",    {31'd0, cpu_en},  32'd1);
    chk_quiet("rst");
    chk("rst_rdata", cpu_rdata,        32'd0);
    chk("rst_addr",  bus_addr,         32'd0);
    chk("rst_wdata", bus_wdata,        32'd0);
    chk("rst_err",   {31'd0, bus_err}, 32'd0);
    chk("rst_eaddr", err_addr,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_en", {31'd0, cpu_en}, 32'd1);

    access(1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678, 0);
    access(1'b1, 32'hE000_0003, 32'hA5A5_A5A5, 3, 32'h0BAD_0BAD, 0);
    access(1'b0, 32'h0000_2000, 32'h0, T, 32'hCAFE_F00D, 0);
    access(1'b0, 32'h0000_0100, 32'h0, 2, 32'h1111_2222, 1);
    access(1'b0, 32'hF000_0204, 32'h0, 1, 32'h3333_4444, 0);

    for (int i = 0; i < 25; i++) begin
      access(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, T + 1)),
             $urandom, bit'($urandom_range(0, 1)));
    end

    access(1'b0, 32'h2000_0040, 32'h0, 0, 32'h0, 0);
    access(1'b1, 32'hF000_0008, 32'h5555_AAAA, 0, 32'h0, 0);

    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0104;
    cpu_wdata = 32'h7777_8888;
    bus_ready = 1'b0;
    #1;
    chk("rs_idle_en", {31'd0, cpu_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("rs_acc_we", {31'd0, bus_we}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs_force_en", {31'd0, cpu_en}, 32'd1);
    @(negedge clk);
    #1;
    chk("rs_hold_en",  {31'd0, cpu_en},  32'd1);
    chk_quiet("rs_hold");
    chk("rs_rdata",    cpu_rdata,        32'd0);
    chk("rs_addr",     bus_addr,         32'd0);
    chk("rs_err",      {31'd0, bus_err}, 32'd0);
    chk("rs_eaddr",    err_addr,         32'd0);
    m_rdata    = 32'd0;
    m_err      = 1'b0;
    m_err_addr = 32'd0;
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rs_idle2_en", {31'd0, cpu_en}, 32'd1);
    chk_quiet("rs_idle2");
    access(1'b1, 32'h0000_0104, 32'h7777_8888, 2, 32'h0, 0);
    access(1'b0, 32'h0000_0104, 32'h0, 1, 32'h9999_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
